// File: rtl/bike_motion_ctrl.sv
`timescale 1ns/1ps
// Light-bike position/orientation sequencer: latches turn requests, steps the sprite every
// FRAMES_PER_STEP VS frames and publishes a linear start address. Define BIKE_WRAP_EN for edge wrap.
module bike_motion_ctrl #(
  parameter int H_RES           = 640,
  parameter int V_RES           = 480,
  parameter int SPRITE          = 30,
  parameter int STEP            = 2,
  parameter int FRAMES_PER_STEP = 2,
  parameter int START_X         = 200,
  parameter int START_Y         = 200
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        iVS,
  input  logic [3:0]  iBtn,
  input  logic        iStart,
  output logic [18:0] oBikeLoc,
  output logic [1:0]  oBikeOrient,
  output logic        oRunning,
  output logic        oCrash,
  output logic        oStepTick
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CRASHED} state_t;

  localparam logic [9:0]         START_X_C = 10'(START_X);
  localparam logic [8:0]         START_Y_C = 9'(START_Y);
  localparam logic signed [10:0] X_MAX     = 11'(H_RES - SPRITE);
  localparam logic signed [10:0] Y_MAX     = 11'(V_RES - SPRITE);
  localparam logic signed [10:0] STEP_C    = 11'(STEP);
  localparam logic [3:0]         CNT_LAST  = 4'(FRAMES_PER_STEP - 1);
  localparam logic [18:0]        LOC_RST   = 19'(START_Y * H_RES + START_X);

  function automatic logic [18:0] lin_addr(input logic [9:0] x, input logic [8:0] y);
    if (H_RES == 640)
      return {1'b0, y, 9'd0} + {3'b0, y, 7'd0} + {9'd0, x};
    else
      return 19'(y * H_RES + x);
  endfunction

  function automatic logic req_ok(input logic [3:0] b, input logic [1:0] rd, input logic [1:0] o);
    return (|b) && (rd != o) && (rd != (o ^ 2'd2));
  endfunction

  logic [3:0]  btn_s1_q, btn_s2_q;
  logic        start_s1_q, start_s2_q, start_s3_q;
  logic        vs_s1_q, vs_s2_q, vs_s3_q;
  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [1:0]  orient_q, orient_d;
  logic        pend_vld_q, pend_vld_d;
  logic [1:0]  pend_dir_q, pend_dir_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [18:0] loc_q, loc_d;
  logic        tick_q, tick_d;

  logic        frame_tick, start_rise;
  logic [1:0]  req_dir, step_orient;
  logic signed [10:0] dx, dy, nx, ny;

  assign frame_tick = vs_s3_q & ~vs_s2_q;
  assign start_rise = start_s2_q & ~start_s3_q;

  // Lowest set request bit wins.
  always_comb begin
    req_dir = 2'd3;
    if (btn_s2_q[0])      req_dir = 2'd0;
    else if (btn_s2_q[1]) req_dir = 2'd1;
    else if (btn_s2_q[2]) req_dir = 2'd2;
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    orient_d   = orient_q;
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;
    cnt_d      = cnt_q;
    tick_d     = 1'b0;
    step_orient = pend_vld_q ? pend_dir_q : orient_q;
    dx = '0;
    dy = '0;
    case (step_orient)
      2'd0:    dy = -STEP_C;
      2'd1:    dx = STEP_C;
      2'd2:    dy = STEP_C;
      default: dx = -STEP_C;
    endcase
    nx = $signed({1'b0, x_q}) + dx;
    ny = $signed({2'b0, y_q}) + dy;
    case (state_q)
      S_RUN: begin
        if (req_ok(btn_s2_q, req_dir, orient_q)) begin
          pend_vld_d = 1'b1;
          pend_dir_d = req_dir;
        end
        if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            orient_d   = step_orient;
            pend_vld_d = 1'b0;
            // A request seen in the step cycle is judged against the new heading and kept.
            if (req_ok(btn_s2_q, req_dir, step_orient)) begin
              pend_vld_d = 1'b1;
              pend_dir_d = req_dir;
            end
            if (nx < 0 || nx > X_MAX || ny < 0 || ny > Y_MAX) begin
`ifdef BIKE_WRAP_EN
              x_d    = (nx < 0) ? X_MAX[9:0] : (nx > X_MAX) ? 10'd0 : nx[9:0];
              y_d    = (ny < 0) ? Y_MAX[8:0] : (ny > Y_MAX) ? 9'd0 : ny[8:0];
              tick_d = 1'b1;
`else
              state_d = S_CRASHED;
`endif
            end else begin
              x_d    = nx[9:0];
              y_d    = ny[8:0];
              tick_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        if (start_rise) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          pend_vld_d = 1'b0;
          orient_d   = 2'd1;
          x_d        = START_X_C;
          y_d        = START_Y_C;
        end
      end
    endcase
    loc_d = lin_addr(x_d, y_d);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      start_s3_q <= 1'b0;
      vs_s1_q    <= 1'b1;
      vs_s2_q    <= 1'b1;
      vs_s3_q    <= 1'b1;
      state_q    <= S_IDLE;
      x_q        <= START_X_C;
      y_q        <= START_Y_C;
      orient_q   <= 2'd1;
      pend_vld_q <= 1'b0;
      pend_dir_q <= 2'd0;
      cnt_q      <= '0;
      loc_q      <= LOC_RST;
      tick_q     <= 1'b0;
    end else begin
      btn_s1_q   <= iBtn;
      btn_s2_q   <= btn_s1_q;
      start_s1_q <= iStart;
      start_s2_q <= start_s1_q;
      start_s3_q <= start_s2_q;
      vs_s1_q    <= iVS;
      vs_s2_q    <= vs_s1_q;
      vs_s3_q    <= vs_s2_q;
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      orient_q   <= orient_d;
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
      cnt_q      <= cnt_d;
      loc_q      <= loc_d;
      tick_q     <= tick_d;
    end
  end

  assign oBikeLoc    = loc_q;
  assign oBikeOrient = orient_q;
  assign oRunning    = (state_q == S_RUN);
  assign oStepTick   = tick_q;
`ifdef BIKE_WRAP_EN
  assign oCrash      = 1'b0;
`else
  assign oCrash      = (state_q == S_CRASHED);
`endif

endmodule

// File: tb/tb_bike_motion_ctrl.sv
`timescale 1ns/1ps
// Bench for bike_motion_ctrl: directed vectors, hand sequences and a frame-level reference model.
module tb_bike_motion_ctrl;

  localparam int FPS = 2;
  localparam int XM  = 610;
  localparam int YM  = 450;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  btn = 4'd0;
  logic [18:0] loc, loc2;
  logic [1:0]  orient, orient2;
  logic        running, running2, crash, crash2, tick, tick2;

  always #5 clk = ~clk;

  bike_motion_ctrl dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(vs), .iBtn(btn), .iStart(start),
    .oBikeLoc(loc), .oBikeOrient(orient), .oRunning(running), .oCrash(crash), .oStepTick(tick)
  );

  bike_motion_ctrl #(.START_X(606)) dut2 (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(vs), .iBtn(btn), .iStart(start),
    .oBikeLoc(loc2), .oBikeOrient(orient2), .oRunning(running2), .oCrash(crash2), .oStepTick(tick2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Frame-level reference model: position, heading, pending turn, frame count, mode.
  int mx, my, mdir, mpend, mcnt, mst;  // mst: 0 idle, 1 run, 2 crashed

  function automatic int lowbit(input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) return i;
    return -1;
  endfunction

  function automatic bit mvalid(input logic [3:0] b, input int d);
    int r;
    r = lowbit(b);
    return (r >= 0) && (r != d) && (r != ((d + 2) % 4));
  endfunction

  task automatic model_reset();
    mx = 200; my = 200; mdir = 1; mpend = -1; mcnt = 0; mst = 0;
  endtask

  task automatic model_frame(input logic [3:0] b, output int et);
    int nx, ny;
    et = 0;
    if (mst == 1) begin
      if (mvalid(b, mdir)) mpend = lowbit(b);
      if (mcnt == FPS - 1) begin
        mcnt = 0;
        if (mpend >= 0) mdir = mpend;
        mpend = -1;
        nx = mx; ny = my;
        case (mdir)
          0: ny -= 2;
          1: nx += 2;
          2: ny += 2;
          default: nx -= 2;
        endcase
        if (nx < 0 || nx > XM || ny < 0 || ny > YM) begin
`ifdef BIKE_WRAP_EN
          if (nx > XM) nx = 0; else if (nx < 0) nx = XM;
          if (ny > YM) ny = 0; else if (ny < 0) ny = YM;
          mx = nx; my = ny; et = 1;
`else
          mst = 2;
`endif
        end else begin
          mx = nx; my = ny; et = 1;
        end
        if (mst == 1 && mvalid(b, mdir)) mpend = lowbit(b);
      end else begin
        mcnt++;
      end
    end
  endtask

  task automatic model_start();
    if (mst != 1) begin
      mst = 1; mcnt = 0; mpend = -1; mdir = 1; mx = 200; my = 200;
    end
  endtask

  // One VS frame: high 8 cycles with btn applied, then low 8 cycles while watching oStepTick.
  task automatic frame(input logic [3:0] b, output int t_at, output int t_cnt);
    @(negedge clk);
    vs = 1'b1;
    btn = b;
    repeat (8) @(negedge clk);
    vs = 1'b0;
    t_at = -1;
    t_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (tick) begin
        t_cnt++;
        if (t_at < 0) t_at = k;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    btn = 4'd0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_all(input string tag, input int et, input int t_at, input int t_cnt);
    chk({tag, "_loc"}, int'(loc), my * 640 + mx);
    chk({tag, "_orient"}, int'(orient), mdir);
    chk({tag, "_running"}, int'(running), (mst == 1) ? 1 : 0);
    chk({tag, "_crash"}, int'(crash), (mst == 2) ? 1 : 0);
    chk({tag, "_tick_cnt"}, t_cnt, et);
    // Pin-to-output latency: two synchroniser stages, edge detect, registered output.
    chk({tag, "_tick_at"}, t_at, et ? 3 : -1);
  endtask

  typedef struct {
    logic [3:0] btn;
    int         orient;
    int         loc;
    int         tick;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_at, t_cnt, et;
    logic [3:0] rb;

    tbl[0]  = '{4'b0100, 1, 128200, 0};
    tbl[1]  = '{4'b0000, 2, 129480, 1};
    tbl[2]  = '{4'b0000, 2, 129480, 0};
    tbl[3]  = '{4'b1000, 3, 129478, 1};
    tbl[4]  = '{4'b0010, 3, 129478, 0};
    tbl[5]  = '{4'b0000, 3, 129476, 1};
    tbl[6]  = '{4'b0101, 3, 129476, 0};
    tbl[7]  = '{4'b0100, 2, 130756, 1};
    tbl[8]  = '{4'b0100, 2, 130756, 0};
    tbl[9]  = '{4'b0000, 2, 132036, 1};
    tbl[10] = '{4'b0001, 2, 132036, 0};
    tbl[11] = '{4'b0010, 1, 132038, 1};
    tbl[12] = '{4'b1000, 1, 132038, 0};
    tbl[13] = '{4'b1000, 1, 132040, 1};

    // Reset and idle behaviour
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_loc", int'(loc), 128200);
    chk("rst_orient", int'(orient), 1);
    chk("rst_running", int'(running), 0);
    chk("rst_crash", int'(crash), 0);
    chk("rst_tick", int'(tick), 0);
    for (int f = 0; f < 5; f++) begin
      frame(4'b0100, t_at, t_cnt);
      model_frame(4'b0100, et);
      check_all("idle", et, t_at, t_cnt);
    end

    // Run right, second instance heads for the right edge
    pulse_start();
    model_start();
    chk("start_running", int'(running), 1);
    for (int f = 0; f < 6; f++) begin
      frame(4'b0000, t_at, t_cnt);
      model_frame(4'b0000, et);
      check_all("run", et, t_at, t_cnt);
      if (f == 3) begin
        chk("run4_loc", int'(loc), 128204);
        chk("edge_pre_loc", int'(loc2), 128610);
      end
    end
`ifdef BIKE_WRAP_EN
    chk("wrap_crash", int'(crash2), 0);
    chk("wrap_loc", int'(loc2), 128000);
    chk("wrap_running", int'(running2), 1);
`else
    chk("crash_flag", int'(crash2), 1);
    chk("crash_loc", int'(loc2), 128610);
    chk("crash_running", int'(running2), 0);
`endif
    for (int f = 0; f < 2; f++) begin
      frame(4'b0000, t_at, t_cnt);
      model_frame(4'b0000, et);
      check_all("run_b", et, t_at, t_cnt);
    end
`ifdef BIKE_WRAP_EN
    chk("wrap_move_loc", int'(loc2), 128002);
`else
    chk("crash_frozen_loc", int'(loc2), 128610);
    chk("crash_frozen_flag", int'(crash2), 1);
`endif
    pulse_start();
    model_start();
`ifdef BIKE_WRAP_EN
    chk("restart_ign_loc", int'(loc2), 128002);
`else
    chk("restart_loc", int'(loc2), 128606);
    chk("restart_running", int'(running2), 1);
    chk("restart_crash", int'(crash2), 0);
`endif
    chk("restart_main_loc", int'(loc), my * 640 + mx);

    // Asynchronous reset between VS edges
    @(negedge clk);
    vs = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_loc", int'(loc), 128200);
    chk("arst_orient", int'(orient), 1);
    chk("arst_running", int'(running), 0);
    chk("arst_running2", int'(running2), 0);
    chk("arst_crash2", int'(crash2), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    frame(4'b0000, t_at, t_cnt);
    model_frame(4'b0000, et);
    check_all("arst_idle", et, t_at, t_cnt);

    // Table-driven turn vectors
    pulse_start();
    model_start();
    for (int i = 0; i < 14; i++) begin
      frame(tbl[i].btn, t_at, t_cnt);
      model_frame(tbl[i].btn, et);
      chk($sformatf("vec%0d_orient", i), int'(orient), tbl[i].orient);
      chk($sformatf("vec%0d_loc", i), int'(loc), tbl[i].loc);
      chk($sformatf("vec%0d_tick", i), t_cnt, tbl[i].tick);
    end

    // Request landing exactly in the step cycle survives to the next step
    frame(4'b0000, t_at, t_cnt);
    model_frame(4'b0000, et);
    @(negedge clk);
    vs = 1'b1;
    btn = 4'b0000;
    repeat (8) @(negedge clk);
    vs = 1'b0;
    btn = 4'b0001;
    @(negedge clk);
    btn = 4'b0000;
    repeat (7) @(negedge clk);
    chk("same_cyc_loc", int'(loc), 132042);
    chk("same_cyc_orient", int'(orient), 1);
    mx = 202; mcnt = 0; mpend = 0;
    for (int f = 0; f < 2; f++) begin
      frame(4'b0000, t_at, t_cnt);
      model_frame(4'b0000, et);
      check_all("kept", et, t_at, t_cnt);
    end
    chk("kept_orient", int'(orient), 0);
    chk("kept_loc", int'(loc), 130762);

    // Randomised frames against the model
    for (int f = 0; f < 250; f++) begin
      if (mst != 1 || $urandom_range(0, 49) == 0) begin
        pulse_start();
        model_start();
      end
      rb = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      frame(rb, t_at, t_cnt);
      model_frame(rb, et);
      check_all($sformatf("rnd%0d", f), et, t_at, t_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
